sid_wave: RTL

- Per-voice SID waveform generator.
- Consumes the phase accumulator and noise LFSR state from the voice oscillator.
- Produces the registered 12-bit voice waveform for the envelope multiplier and DAC path.
- Implements triangle with ring modulation, sawtooth, pulse and noise, combined waveforms (bitwise AND), and the floating-output hold/fade that occurs when no waveform is selected.

---
 rtl/sid_wave.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sid_wave.sv
// sid_wave: per-voice SID waveform generator (triangle/ring, saw, pulse, noise,
// AND-combined) with floating-output hold and fade when no waveform is selected.
`default_nettype none

module sid_wave #(
  parameter int HOLD_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        clk_en,
  input  logic [23:0] acc,
  input  logic [22:0] lfsr,
  input  logic        ring_msb,
  input  logic [11:0] pw,
  input  logic [3:0]  wave,
  input  logic        ring,
  input  logic        test,
  output logic [11:0] wave_out,
  output logic        floating
);

  localparam int CW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(HOLD_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_FADE   = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_noise;
  logic [11:0]   r_wave_out;
  logic          r_floating;

  logic          w_t_msb;
  logic [11:0]   w_tri;
  logic [11:0]   w_saw;
  logic [11:0]   w_pul;
  logic [11:0]   w_noi;
  logic [11:0]   w_comb;
  logic [11:0]   w_shift;
  logic          w_sel;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [11:0]   w_out_nxt;
  logic [7:0]    w_noise_nxt;
  logic          w_unused;

  // Only the eight classic noise taps and the top 12 accumulator bits matter.
  assign w_unused = ^{acc[11:0], lfsr[21], lfsr[19:17], lfsr[15:14], lfsr[12],
                      lfsr[10:8], lfsr[6:5], lfsr[3], lfsr[1:0]};

  assign w_noise_nxt = {lfsr[22], lfsr[20], lfsr[16], lfsr[13],
                        lfsr[11], lfsr[7], lfsr[4], lfsr[2]};

  assign w_t_msb = acc[23] ^ (ring & ring_msb);
  assign w_tri   = {acc[22:12] ^ {11{w_t_msb}}, 1'b0};
  assign w_saw   = acc[23:12];
  assign w_pul   = (test || (acc[23:12] >= pw)) ? 12'hFFF : 12'h000;
  assign w_noi   = {r_noise, 4'h0};
  assign w_sel   = (wave != 4'd0);
  assign w_shift = r_wave_out >> 1;

  always_comb begin
    w_comb = 12'hFFF;
    if (wave[0]) w_comb = w_comb & w_tri;
    if (wave[1]) w_comb = w_comb & w_saw;
    if (wave[2]) w_comb = w_comb & w_pul;
    if (wave[3]) w_comb = w_comb & w_noi;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_wave_out;
    if (w_sel) begin
      w_state_nxt = S_ACTIVE;
      w_out_nxt   = w_comb;
    end else begin
      case (r_state)
        S_ACTIVE: begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end
        S_HOLD: begin
          if (r_cnt == C_CNT_LAST) begin
            // A held value of 0 or 1 shifts straight to zero, so skip FADE.
            w_out_nxt   = w_shift;
            w_state_nxt = (w_shift == 12'd0) ? S_IDLE : S_FADE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_FADE: begin
          w_out_nxt = w_shift;
          if (w_shift == 12'd0) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_out_nxt   = 12'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_noise    <= 8'd0;
      r_wave_out <= 12'd0;
      r_floating <= 1'b1;
    end else if (clk_en) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_noise    <= w_noise_nxt;
      r_wave_out <= w_out_nxt;
      r_floating <= (w_state_nxt != S_ACTIVE);
    end
  end

  assign wave_out = r_wave_out;
  assign floating = r_floating;

endmodule

`default_nettype wire
